// File: rtl/voice_operator_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// voice_operator_scheduler_pkg
//   Shared voice/operator constants, host command encoding and ID helpers.
//   Revision: 1.0
// ============================================================================
package voice_operator_scheduler_pkg;

   localparam int NUM_VOICES          = 12;
   localparam int OPERATORS_PER_VOICE = 6;
   localparam int NUM_VOICE_OPERATORS = NUM_VOICES * OPERATORS_PER_VOICE;
   localparam int VOICE_OPERATOR_ID   = $clog2(NUM_VOICE_OPERATORS);

   typedef logic [VOICE_OPERATOR_ID-1:0] voice_op_id_t;

   typedef enum logic [1:0] {
      CMD_PHASE_STEP    = 2'd0,
      CMD_KEY_ON        = 2'd1,
      CMD_KEY_OFF       = 2'd2,
      CMD_ALL_NOTES_OFF = 2'd3
   } cmd_kind_e;

   typedef struct packed {
      cmd_kind_e    kind;
      voice_op_id_t addr;
      logic [15:0]  data;
   } cmd_t;

   // Operators of one voice are contiguous in the frame.
   function automatic voice_op_id_t getVoiceID(input voice_op_id_t op);
      return VOICE_OPERATOR_ID'(int'(op) / OPERATORS_PER_VOICE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/voice_operator_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// config_cmd_fifo
//   Synchronous FIFO, valid/ready push, pop strobe, full/empty flags.
//   DEPTH must be a power of two, at least 2.  Revision: 1.0
// ============================================================================
module config_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic             i_PushValid,
   output logic             o_PushReady,
   input  logic [WIDTH-1:0] i_PushData,
   input  logic             i_Pop,
   output logic [WIDTH-1:0] o_PopData,
   output logic             o_Full,
   output logic             o_Empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             w_push, w_pop;

   assign o_Full      = (count_q == (AW+1)'(DEPTH));
   assign o_Empty     = (count_q == '0);
   assign o_PushReady = !o_Full;
   assign o_PopData   = mem_q[rd_ptr_q];

   assign w_push = i_PushValid && o_PushReady;
   assign w_pop  = i_Pop && !o_Empty;

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge i_Clock) begin
      if (w_push) mem_q[wr_ptr_q] <= i_PushData;
   end

endmodule
`default_nettype wire

// File: rtl/voice_operator_scheduler.sv
`default_nettype none
// ============================================================================
// voice_operator_scheduler
//   Operator sequencer and config-write serialiser with frame-coherent
//   note-on mask commits. Optional SCHED_RETRIGGER_EN: key-on to a held voice
//   forces one frame of note-off.  Revision: 1.0
// ============================================================================
module voice_operator_scheduler #(
   parameter int NUM_OPS    = voice_operator_scheduler_pkg::NUM_VOICE_OPERATORS,
   parameter int NUM_VOICES = voice_operator_scheduler_pkg::NUM_VOICES,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_CmdValid,
   output logic        o_CmdReady,
   input  logic [1:0]  i_CmdKind,
   input  logic [voice_operator_scheduler_pkg::VOICE_OPERATOR_ID-1:0] i_CmdAddr,
   input  logic [15:0] i_CmdData,
   output logic [voice_operator_scheduler_pkg::VOICE_OPERATOR_ID-1:0] o_VoiceOperator,
   output logic        o_FrameStart,
   output logic        o_PhaseStepConfigWriteEnable,
   output logic        o_NoteOnConfigWriteEnable,
   output logic [voice_operator_scheduler_pkg::VOICE_OPERATOR_ID-1:0] o_ConfigWriteAddr,
   output logic [15:0] o_ConfigWriteData,
   output logic        o_CmdError
);

   import voice_operator_scheduler_pkg::*;

   localparam int             OPW     = VOICE_OPERATOR_ID;
   localparam logic [OPW-1:0] LAST_OP = OPW'(NUM_OPS - 1);

   cmd_t                  w_push_cmd, w_head;
   logic                  w_fifo_empty, w_fifo_full, w_push_ready, w_pop;
   logic                  w_launch, w_head_in_range, w_head_is_step;
   logic                  w_dirty_after_commit;
   logic [NUM_VOICES-1:0] w_voice_bit, w_commit_mask;

   logic [OPW-1:0]        op_q, op_d;
   logic                  frame_start_q, frame_start_d;
   logic [NUM_VOICES-1:0] mask_q, mask_d;
   logic                  dirty_q, dirty_d;
   logic                  err_q, err_d;
   logic                  ps_we_q, ps_we_d;
   logic                  no_we_q, no_we_d;
   logic [OPW-1:0]        wr_addr_q, wr_addr_d;
   logic [15:0]           wr_data_q, wr_data_d;

   assign w_push_cmd.kind = cmd_kind_e'(i_CmdKind);
   assign w_push_cmd.addr = i_CmdAddr;
   assign w_push_cmd.data = i_CmdData;

   config_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_PushValid (i_CmdValid && w_push_ready),
      .o_PushReady (w_push_ready),
      .i_PushData  (w_push_cmd),
      .i_Pop       (w_pop),
      .o_PopData   (w_head),
      .o_Full      (w_fifo_full),
      .o_Empty     (w_fifo_empty)
   );

   assign op_d          = (op_q == LAST_OP) ? '0 : op_q + 1'b1;
   assign frame_start_d = (op_d == '0);

   // The commit is launched one edge early so that it is on the port while
   // the last operator of the frame is on the bus.
   assign w_launch = (op_d == LAST_OP) && dirty_q;

   always_comb begin
      w_head_in_range = 1'b1;
      if (w_head.kind == CMD_PHASE_STEP)
         w_head_in_range = int'(w_head.addr) < NUM_OPS;
      else if (w_head.kind != CMD_ALL_NOTES_OFF)
         w_head_in_range = int'(w_head.addr) < NUM_VOICES;
   end

   assign w_head_is_step = (w_head.kind == CMD_PHASE_STEP);
   assign w_voice_bit    = NUM_VOICES'(1) << w_head.addr;
   assign w_pop          = !w_fifo_empty && !(w_head_is_step && w_head_in_range && w_launch);

`ifdef SCHED_RETRIGGER_EN
   logic [NUM_VOICES-1:0] retrig_q, retrig_d;

   // Retriggered voices are written as 0 once, then the held mask follows.
   assign w_commit_mask        = mask_q & ~retrig_q;
   assign w_dirty_after_commit = |retrig_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) retrig_q <= '0;
      else         retrig_q <= retrig_d;
   end
`else
   assign w_commit_mask        = mask_q;
   assign w_dirty_after_commit = 1'b0;
`endif

   always_comb begin
      mask_d    = mask_q;
      dirty_d   = dirty_q;
      err_d     = err_q;
      ps_we_d   = 1'b0;
      no_we_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
`ifdef SCHED_RETRIGGER_EN
      retrig_d  = retrig_q;
`endif

      if (w_launch) begin
         no_we_d   = 1'b1;
         wr_data_d = 16'(w_commit_mask);
         dirty_d   = w_dirty_after_commit;
`ifdef SCHED_RETRIGGER_EN
         retrig_d  = '0;
`endif
      end

      if (w_pop) begin
         if (!w_head_in_range) begin
            err_d = 1'b1;
         end else begin
            case (w_head.kind)
               CMD_PHASE_STEP: begin
                  ps_we_d   = 1'b1;
                  wr_addr_d = w_head.addr;
                  wr_data_d = w_head.data;
               end
               CMD_KEY_ON: begin
                  if ((mask_q & w_voice_bit) == '0) begin
                     mask_d  = mask_q | w_voice_bit;
                     dirty_d = 1'b1;
                  end
`ifdef SCHED_RETRIGGER_EN
                  else begin
                     retrig_d = retrig_d | w_voice_bit;
                     dirty_d  = 1'b1;
                  end
`endif
               end
               CMD_KEY_OFF: begin
                  mask_d   = mask_q & ~w_voice_bit;
                  dirty_d  = 1'b1;
`ifdef SCHED_RETRIGGER_EN
                  retrig_d = retrig_d & ~w_voice_bit;
`endif
               end
               default: begin
                  mask_d   = '0;
                  dirty_d  = 1'b1;
`ifdef SCHED_RETRIGGER_EN
                  retrig_d = '0;
`endif
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         op_q          <= '0;
         frame_start_q <= 1'b1;
         mask_q        <= '0;
         dirty_q       <= 1'b1;
         err_q         <= 1'b0;
         ps_we_q       <= 1'b0;
         no_we_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
      end else begin
         op_q          <= op_d;
         frame_start_q <= frame_start_d;
         mask_q        <= mask_d;
         dirty_q       <= dirty_d;
         err_q         <= err_d;
         ps_we_q       <= ps_we_d;
         no_we_q       <= no_we_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
      end
   end

   assign o_CmdReady                   = !w_fifo_full;
   assign o_VoiceOperator              = op_q;
   assign o_FrameStart                 = frame_start_q;
   assign o_PhaseStepConfigWriteEnable = ps_we_q;
   assign o_NoteOnConfigWriteEnable    = no_we_q;
   assign o_ConfigWriteAddr            = wr_addr_q;
   assign o_ConfigWriteData            = wr_data_q;
   assign o_CmdError                   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_operator_scheduler.sv
`default_nettype none
// ============================================================================
// tb_voice_operator_scheduler
//   Directed table, corner sequences and random traffic against a queue model.
//   Revision: 1.0
// ============================================================================
module tb_voice_operator_scheduler;

   localparam int NUM_OPS    = 72;
   localparam int NUM_VOICES = 12;
   localparam int FIFO_DEPTH = 4;

   logic        i_Clock = 1'b0;
   logic        i_Reset = 1'b1;
   logic        i_CmdValid = 1'b0;
   logic [1:0]  i_CmdKind = '0;
   logic [6:0]  i_CmdAddr = '0;
   logic [15:0] i_CmdData = '0;
   logic        o_CmdReady;
   logic [6:0]  o_VoiceOperator;
   logic        o_FrameStart;
   logic        o_PhaseStepConfigWriteEnable;
   logic        o_NoteOnConfigWriteEnable;
   logic [6:0]  o_ConfigWriteAddr;
   logic [15:0] o_ConfigWriteData;
   logic        o_CmdError;

   int n_checks = 0;
   int n_errs   = 0;

   voice_operator_scheduler dut (
      .i_Clock                      (i_Clock),
      .i_Reset                      (i_Reset),
      .i_CmdValid                   (i_CmdValid),
      .o_CmdReady                   (o_CmdReady),
      .i_CmdKind                    (i_CmdKind),
      .i_CmdAddr                    (i_CmdAddr),
      .i_CmdData                    (i_CmdData),
      .o_VoiceOperator              (o_VoiceOperator),
      .o_FrameStart                 (o_FrameStart),
      .o_PhaseStepConfigWriteEnable (o_PhaseStepConfigWriteEnable),
      .o_NoteOnConfigWriteEnable    (o_NoteOnConfigWriteEnable),
      .o_ConfigWriteAddr            (o_ConfigWriteAddr),
      .o_ConfigWriteData            (o_ConfigWriteData),
      .o_CmdError                   (o_CmdError)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: command queue + frame rules ----------
   typedef struct {
      logic [1:0]  kind;
      int          addr;
      logic [15:0] data;
   } mcmd_t;

   mcmd_t     mq[$];
   int        m_op;
   bit        m_frame, m_pwe, m_nwe, m_dirty, m_err;
   bit [6:0]  m_addr;
   bit [15:0] m_data;
   bit [NUM_VOICES-1:0] m_mask, m_pend;

   task automatic model_edge();
      mcmd_t h;
      bit    accept, launch;
      int    nxt;
      if (i_Reset) begin
         mq.delete();
         m_op = 0; m_frame = 1; m_pwe = 0; m_nwe = 0; m_addr = 0; m_data = 0;
         m_mask = 0; m_pend = 0; m_dirty = 1; m_err = 0;
         return;
      end
      accept = i_CmdValid && (mq.size() < FIFO_DEPTH);
      nxt    = (m_op + 1) % NUM_OPS;
      launch = (nxt == NUM_OPS - 1) && m_dirty;
      m_pwe = 0; m_nwe = 0; m_addr = 0; m_data = 0;
      if (launch) begin
         m_nwe   = 1;
         m_data  = 16'(m_mask & ~m_pend);
         m_dirty = (m_pend != 0);
         m_pend  = 0;
      end
      if (mq.size() > 0) begin
         h = mq[0];
         if (!(h.kind == 0 && h.addr < NUM_OPS && launch)) begin
            void'(mq.pop_front());
            case (h.kind)
               2'd0: if (h.addr >= NUM_OPS) m_err = 1;
                     else begin m_pwe = 1; m_addr = 7'(h.addr); m_data = h.data; end
               2'd1: if (h.addr >= NUM_VOICES) m_err = 1;
                     else if (!m_mask[h.addr]) begin m_mask[h.addr] = 1; m_dirty = 1; end
`ifdef SCHED_RETRIGGER_EN
                     else begin m_pend[h.addr] = 1; m_dirty = 1; end
`endif
               2'd2: if (h.addr >= NUM_VOICES) m_err = 1;
                     else begin m_mask[h.addr] = 0; m_pend[h.addr] = 0; m_dirty = 1; end
               default: begin m_mask = 0; m_pend = 0; m_dirty = 1; end
            endcase
         end
      end
      if (accept) mq.push_back('{i_CmdKind, int'(i_CmdAddr), i_CmdData});
      m_op    = nxt;
      m_frame = (m_op == 0);
   endtask

   always @(posedge i_Clock) begin
      model_edge();
      #1;
      check("cycle_vs_model",
            {o_VoiceOperator, o_FrameStart, o_PhaseStepConfigWriteEnable,
             o_NoteOnConfigWriteEnable, o_ConfigWriteAddr, o_ConfigWriteData,
             o_CmdReady, o_CmdError},
            {7'(m_op), m_frame, m_pwe, m_nwe, m_addr, m_data,
             (mq.size() < FIFO_DEPTH), m_err});
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic wait_op(input int target);
      bit found = 0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge i_Clock);
         if (o_VoiceOperator == 7'(target)) found = 1;
      end
      if (!found) begin
         n_checks++; n_errs++;
         $display("FAIL wait_op: operator %0d not reached within 300 cycles", target);
      end
   endtask

   task automatic send(input logic [1:0] kind, input int addr, input logic [15:0] data);
      bit done = 0;
      i_CmdValid = 1; i_CmdKind = kind; i_CmdAddr = 7'(addr); i_CmdData = data;
      for (int k = 0; k < 50 && !done; k++) begin
         if (o_CmdReady) done = 1;
         @(negedge i_Clock);
      end
      i_CmdValid = 0;
      if (!done) begin
         n_checks++; n_errs++;
         $display("FAIL send: command not accepted within 50 cycles (ready=%0b)", o_CmdReady);
      end
   endtask

   typedef struct {
      logic [1:0]  kind;
      int          addr;
      logic [15:0] data;
      logic        exp_pwe;
      logic [6:0]  exp_addr;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int cnt;
      bit found;
      logic [22:0] wq[$];
      logic [15:0] cq[$];

      vecs[0] = '{2'd0,  5, 16'h1234, 1'b1, 7'd5,  16'h1234, 1'b0};
      vecs[1] = '{2'd0,  0, 16'h0001, 1'b1, 7'd0,  16'h0001, 1'b0};
      vecs[2] = '{2'd0, 71, 16'hFFFF, 1'b1, 7'd71, 16'hFFFF, 1'b0};
      vecs[3] = '{2'd1, 11, 16'hAAAA, 1'b0, 7'd0,  16'h0000, 1'b0};
      vecs[4] = '{2'd2, 11, 16'h5555, 1'b0, 7'd0,  16'h0000, 1'b0};
      vecs[5] = '{2'd3, 99, 16'h0F0F, 1'b0, 7'd0,  16'h0000, 1'b0};
      vecs[6] = '{2'd0, 72, 16'h7777, 1'b0, 7'd0,  16'h0000, 1'b1};
      vecs[7] = '{2'd1, 12, 16'h0000, 1'b0, 7'd0,  16'h0000, 1'b1};

      // Reset state and two full frames of sequencing.
      repeat (3) @(negedge i_Clock);
      i_Reset = 0;
      check("rst_ready", o_CmdReady, 1);
      check("rst_err", o_CmdError, 0);
      check("rst_we", {o_PhaseStepConfigWriteEnable, o_NoteOnConfigWriteEnable}, 0);
      check("rst_addr_data", {o_ConfigWriteAddr, o_ConfigWriteData}, 0);
      cnt = 0;
      for (int i = 0; i < 2 * NUM_OPS; i++) begin
         check("op_seq", o_VoiceOperator, i % NUM_OPS);
         check("frame_start", o_FrameStart, (i % NUM_OPS) == 0);
         if (o_NoteOnConfigWriteEnable) begin
            cnt++;
            check("init_commit_op", o_VoiceOperator, NUM_OPS - 1);
            check("init_commit_data", o_ConfigWriteData, 0);
         end
         @(negedge i_Clock);
      end
      check("init_commit_count", cnt, 1);

      // Key on voices 3 and 7 mid-frame: one commit, none the next frame.
      wait_op(20);
      send(2'd1, 3, 16'h0);
      send(2'd1, 7, 16'h0);
      found = 0;
      for (int k = 0; k < 150 && !found; k++) begin
         if (o_NoteOnConfigWriteEnable) found = 1;
         else @(negedge i_Clock);
      end
      check("key_commit_seen", found, 1);
      check("key_commit_op", o_VoiceOperator, 71);
      check("key_commit_data", o_ConfigWriteData, 16'h0088);
      cnt = 0;
      repeat (NUM_OPS) begin
         @(negedge i_Clock);
         if (o_NoteOnConfigWriteEnable) cnt++;
      end
      check("no_recommit", cnt, 0);

      // Phase step at the head in the commit-launch cycle.
      send(2'd1, 0, 16'h0);
      wait_op(69);
      send(2'd0, 9, 16'hBEEF);
      @(negedge i_Clock);
      check("collide_commit_we", {o_NoteOnConfigWriteEnable, o_PhaseStepConfigWriteEnable}, 2'b10);
      check("collide_commit_data", o_ConfigWriteData, 16'h0089);
      @(negedge i_Clock);
      check("collide_step_we", {o_NoteOnConfigWriteEnable, o_PhaseStepConfigWriteEnable}, 2'b01);
      check("collide_step_addr_data", {o_ConfigWriteAddr, o_ConfigWriteData}, {7'd9, 16'hBEEF});

      // Six back-to-back phase steps issue in order.
      wait_op(5);
      fork
         for (int k = 0; k < 6; k++) send(2'd0, 20 + k, 16'h0100 + 16'(k));
         repeat (20) begin
            @(negedge i_Clock);
            if (o_PhaseStepConfigWriteEnable) wq.push_back({o_ConfigWriteAddr, o_ConfigWriteData});
         end
      join
      check("burst_count", wq.size(), 6);
      for (int k = 0; k < 6 && k < wq.size(); k++)
         check("burst_order", wq[k], {7'(20 + k), 16'h0100 + 16'(k)});

      // Table: one command each, write visible after the second edge.
      for (int v = 0; v < 8; v++) begin
         wait_op(10);
         send(vecs[v].kind, vecs[v].addr, vecs[v].data);
         @(posedge i_Clock); #1;
         check("vec_pwe", o_PhaseStepConfigWriteEnable, vecs[v].exp_pwe);
         check("vec_nwe", o_NoteOnConfigWriteEnable, 0);
         check("vec_addr", o_ConfigWriteAddr, vecs[v].exp_addr);
         check("vec_data", o_ConfigWriteData, vecs[v].exp_data);
         check("vec_err", o_CmdError, vecs[v].exp_err);
      end

      // Reset mid-frame with a queued phase step.
      wait_op(30);
      send(2'd0, 40, 16'h4040);
      i_Reset = 1;
      @(negedge i_Clock);
      i_Reset = 0;
      check("midrst_op", {o_VoiceOperator, o_FrameStart}, {7'd0, 1'b1});
      check("midrst_flags", {o_PhaseStepConfigWriteEnable, o_CmdError, o_CmdReady}, 3'b001);
      cnt = 0;
      repeat (5) begin
         @(negedge i_Clock);
         if (o_PhaseStepConfigWriteEnable) cnt++;
      end
      check("midrst_dropped", cnt, 0);

      // Key on voice 2, then again after it has been committed.
      wait_op(10);
      send(2'd1, 2, 16'h0);
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge i_Clock);
         if (o_NoteOnConfigWriteEnable) found = 1;
      end
      check("retrig_first", {found, o_ConfigWriteData}, {1'b1, 16'h0004});
      wait_op(10);
      send(2'd1, 2, 16'h0);
      repeat (2 * NUM_OPS) begin
         @(negedge i_Clock);
         if (o_NoteOnConfigWriteEnable) cq.push_back(o_ConfigWriteData);
      end
`ifdef SCHED_RETRIGGER_EN
      check("retrig_count", cq.size(), 2);
      if (cq.size() == 2) begin
         check("retrig_zero", cq[0], 16'h0000);
         check("retrig_one", cq[1], 16'h0004);
      end
`else
      check("rekey_noop", cq.size(), 0);
`endif

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         i_Reset    = ($urandom_range(0, 999) == 0);
         i_CmdValid = $urandom_range(0, 1) == 1;
         i_CmdKind  = 2'($urandom_range(0, 3));
         i_CmdAddr  = (i_CmdKind == 2'd0) ? 7'($urandom_range(0, 75)) : 7'($urandom_range(0, 13));
         i_CmdData  = 16'($urandom);
         @(negedge i_Clock);
      end
      i_Reset = 0;
      i_CmdValid = 0;
      repeat (10) @(negedge i_Clock);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
